bitcoin_mem_responder: RTL and testbench

Synchronous word-addressed memory that answers the hash core's memory master port (`mem_we`/`mem_addr`/`mem_write_data` in, `mem_read_data` out) with one-cycle read latency. It is the responder end of the core's message-read and hash-write traffic. It also provides a host load/dump port for preloading the 19-word block header and collecting the 16 nonce hashes. An ownership FSM follows the core's `start`/`done` pair: the core owns the array for the whole run and host accesses stall during it.

---
 rtl/bitcoin_mem_responder.sv | 123 ++++++++++++
 tb/tb_bitcoin_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_mem_responder.sv
// Word-addressed memory answering the hash core's memory master port, with a
// host load/dump port that is locked out while the core owns the array.
module bitcoin_mem_responder #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] OOR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_start,
  input  logic        core_done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        core_owns,
  output logic [7:0]  core_wr_cnt,
  output logic        err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  typedef enum logic [1:0] {
    HOST     = 2'd0,
    CORE_ARM = 2'd1,
    CORE_RUN = 2'd2
  } own_state_t;

  own_state_t  state_r, state_next;
  logic [31:0] mem_r [DEPTH];
  logic [31:0] rd_data_r, host_rdata_r;
  logic        host_ack_r, owns_r, err_r;
  logic [7:0]  wr_cnt_r;

  logic core_in_range_s, host_in_range_s, owned_s;
  logic host_svc_s, core_wr_s, host_wr_s, err_set_s;

  // Address decode and access qualification for both ports
  always_comb begin
    core_in_range_s = ({1'b0, mem_addr} < DEPTH_LIM);
    host_in_range_s = ({1'b0, host_addr} < DEPTH_LIM);
    owned_s         = (state_r != HOST);
    host_svc_s      = host_req && !owned_s && !host_ack_r;
    core_wr_s       = mem_we && owned_s && core_in_range_s;
    host_wr_s       = host_svc_s && host_we && host_in_range_s;
    // Core out-of-range reads only count as errors while the core owns the array
    err_set_s       = (mem_we && !owned_s) ||
                      (owned_s && !core_in_range_s) ||
                      (host_svc_s && !host_in_range_s);
  end

  // Ownership next-state: the ARM state waits for done to drop after start
  always_comb begin
    state_next = state_r;
    case (state_r)
      HOST: begin
        if (core_start) state_next = CORE_ARM;
        else            state_next = HOST;
      end
      CORE_ARM: begin
        if (!core_done) state_next = CORE_RUN;
        else            state_next = CORE_ARM;
      end
      CORE_RUN: begin
        if (core_done) state_next = HOST;
        else           state_next = CORE_RUN;
      end
      default: state_next = HOST;
    endcase
  end

  // Ownership state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= HOST;
      owns_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      owns_r  <= (state_next != HOST);
    end
  end

  // Array storage; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (core_wr_s)      mem_r[mem_addr[AW-1:0]]  <= mem_write_data;
    else if (host_wr_s) mem_r[host_addr[AW-1:0]] <= host_wdata;
  end

  // Read ports, host handshake, write counter and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_r    <= 32'd0;
      host_ack_r   <= 1'b0;
      host_rdata_r <= 32'd0;
      wr_cnt_r     <= 8'd0;
      err_r        <= 1'b0;
    end else begin
      rd_data_r  <= core_in_range_s ? mem_r[mem_addr[AW-1:0]] : OOR_DATA;
      host_ack_r <= host_svc_s;
      if (host_svc_s && !host_we)
        host_rdata_r <= host_in_range_s ? mem_r[host_addr[AW-1:0]] : OOR_DATA;
      if ((state_r == HOST) && core_start)
        wr_cnt_r <= 8'd0;
      else if (core_wr_s && (wr_cnt_r != 8'hFF))
        wr_cnt_r <= wr_cnt_r + 8'd1;
      if (err_set_s) err_r <= 1'b1;
    end
  end

  assign mem_read_data = rd_data_r;
  assign host_ack      = host_ack_r;
  assign host_rdata    = host_rdata_r;
  assign core_owns     = owns_r;
  assign core_wr_cnt   = wr_cnt_r;
  assign err           = err_r;

endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// Directed bench for bitcoin_mem_responder: the bench plays both the hash core
// and the host, checking against a transaction-level memory/ownership model.
module tb_bitcoin_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_start = 1'b0, core_done = 1'b1, mem_we = 1'b0;
  logic [15:0] mem_addr = 16'd0;
  logic [31:0] mem_write_data = 32'd0;
  logic [31:0] mem_read_data;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [15:0] host_addr = 16'd0;
  logic [31:0] host_wdata = 32'd0;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        core_owns;
  logic [7:0]  core_wr_cnt;
  logic        err;

  bitcoin_mem_responder #(.DEPTH(DEPTH), .OOR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset_n(reset_n), .core_start(core_start), .core_done(core_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .core_owns(core_owns), .core_wr_cnt(core_wr_cnt),
    .err(err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the array, what each port must return, sticky error
  logic [31:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  bit          m_owns = 1'b0, m_busy_seen = 1'b0, m_ack = 1'b0, m_err = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_rd = 32'd0, m_hrd = 32'd0;
  bit          m_rd_known = 1'b1, m_hrd_known = 1'b1;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_owns = 0; m_busy_seen = 0; m_ack = 0; m_err = 0; m_cnt = 0;
      m_rd = 32'd0; m_hrd = 32'd0; m_rd_known = 1; m_hrd_known = 1;
    end else begin : step
      int ca, ha;
      bit c_in, h_in, svc;
      ca = int'(mem_addr); ha = int'(host_addr);
      c_in = ca < DEPTH;   h_in = ha < DEPTH;
      if (c_in) begin
        m_rd = m_mem[ca]; m_rd_known = m_val[ca];
      end else begin
        m_rd = 32'hDEADBEEF; m_rd_known = 1;
        if (m_owns) m_err = 1;
      end
      svc = host_req && !m_owns && !m_ack;
      if (svc && !host_we) begin
        if (h_in) begin m_hrd = m_mem[ha]; m_hrd_known = m_val[ha]; end
        else begin m_hrd = 32'hDEADBEEF; m_hrd_known = 1; m_err = 1; end
      end
      if (svc && host_we) begin
        if (h_in) begin m_mem[ha] = host_wdata; m_val[ha] = 1; end
        else m_err = 1;
      end
      if (mem_we) begin
        if (!m_owns || !c_in) m_err = 1;
        else begin
          m_mem[ca] = mem_write_data; m_val[ca] = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      m_ack = svc;
      if (!m_owns && core_start) begin
        m_owns = 1; m_busy_seen = 0; m_cnt = 0;
      end else if (m_owns && !m_busy_seen && !core_done) m_busy_seen = 1;
      else if (m_owns && m_busy_seen && core_done) m_owns = 0;
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("core_owns", 32'(core_owns), 32'(m_owns));
      check("host_ack", 32'(host_ack), 32'(m_ack));
      check("core_wr_cnt", 32'(core_wr_cnt), 32'(m_cnt));
      check("err", 32'(err), 32'(m_err));
      if (m_rd_known) check("mem_read_data", mem_read_data, m_rd);
      if (m_ack && m_hrd_known) check("host_rdata", host_rdata, m_hrd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic host_access(input bit we, input logic [15:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output bit owned_seen);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    owned_seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      cyc();
      if (host_ack) break;
      if (core_owns) owned_seen = 1'b1;
    end
    check("host_ack_seen", 32'(host_ack), 32'd1);
    check("ack_not_while_owned", 32'(core_owns), 32'd0);
    rd = host_rdata;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic core_run();
    core_start = 1'b1; cyc(); core_start = 1'b0; core_done = 1'b0;
    for (int i = 0; i < 19; i++) begin
      mem_addr = 16'(i); cyc();
      check("core_read", mem_read_data, 32'h01000000 + 32'(i));
    end
    for (int k = 0; k < 16; k++) begin
      mem_we = 1'b1; mem_addr = 16'(32 + k); mem_write_data = 32'hA5A50000 + 32'(k);
      cyc();
    end
    mem_we = 1'b0; mem_addr = 16'd0; core_done = 1'b1; cyc();
    check("run_end_owns", 32'(core_owns), 32'd0);
    check("run_end_cnt", 32'(core_wr_cnt), 32'd16);
  endtask

  logic [31:0] hr;
  bit          ow;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_owns", 32'(core_owns), 32'd0);
    check("reset_ack", 32'(host_ack), 32'd0);
    check("reset_rd", mem_read_data, 32'd0);
    check("reset_hrd", host_rdata, 32'd0);
    check("reset_cnt", 32'(core_wr_cnt), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Preload the block header area, then a full core run
    for (int i = 0; i < 20; i++) host_access(1'b1, 16'(i), 32'h01000000 + 32'(i), hr, ow);
    core_run();
    check("run_err", 32'(err), 32'd0);
    for (int k = 0; k < 16; k++) begin
      host_access(1'b0, 16'(32 + k), 32'd0, hr, ow);
      check("hash_dump", hr, 32'hA5A50000 + 32'(k));
    end

    // Core read latency in host state
    mem_addr = 16'd5; cyc();
    mem_addr = 16'd6; check("lat5", mem_read_data, 32'h01000005); cyc();
    mem_addr = 16'd7; check("lat6", mem_read_data, 32'h01000006); cyc();
    mem_addr = 16'd0; check("lat7", mem_read_data, 32'h01000007); cyc();

    // Out-of-range host accesses
    host_access(1'b0, 16'h0100, 32'd0, hr, ow);
    check("oor_read", hr, 32'hDEADBEEF);
    check("oor_err", 32'(err), 32'd1);
    host_access(1'b1, 16'h0100, 32'h12345678, hr, ow);
    host_access(1'b0, 16'h0000, 32'd0, hr, ow);
    check("oor_no_alias", hr, 32'h01000000);

    // Host read stalled behind a core run
    fork
      core_run();
      begin
        cyc(); cyc();
        host_access(1'b0, 16'd3, 32'd0, hr, ow);
        check("stall_seen", 32'(ow), 32'd1);
        check("stall_data", hr, 32'h01000003);
      end
    join
    cyc();

    // Read-during-write on the core port
    core_start = 1'b1; cyc(); core_start = 1'b0; core_done = 1'b0;
    mem_addr = 16'd9; mem_we = 1'b1; mem_write_data = 32'hCAFEF00D; cyc();
    check("rdw_old", mem_read_data, 32'h01000009);
    mem_we = 1'b0; cyc();
    check("rdw_new", mem_read_data, 32'hCAFEF00D);
    core_done = 1'b1; mem_addr = 16'd0; cyc();
    check("rdw_cnt", 32'(core_wr_cnt), 32'd1);

    // Reset in the middle of a run
    core_start = 1'b1; cyc(); core_start = 1'b0; core_done = 1'b0; cyc();
    for (int k = 0; k < 3; k++) begin
      mem_we = 1'b1; mem_addr = 16'(40 + k); mem_write_data = 32'h77770000 + 32'(k); cyc();
    end
    mem_we = 1'b0; mem_addr = 16'd0;
    check("pre_reset_owns", 32'(core_owns), 32'd1);
    reset_n = 1'b0; #1;
    check("midrst_owns", 32'(core_owns), 32'd0);
    check("midrst_cnt", 32'(core_wr_cnt), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    cyc(); cyc();
    reset_n = 1'b1; core_done = 1'b1; cyc();
    host_access(1'b0, 16'd2, 32'd0, hr, ow);
    check("post_rst_preload", hr, 32'h01000002);
    host_access(1'b0, 16'd41, 32'd0, hr, ow);
    check("post_rst_partial", hr, 32'h77770001);
    cyc(); cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
